// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC controller: FSM state encoding and default sizing.
package tdc_pkg;

    localparam int TDC_N_DEF      = 32;
    localparam int TDC_SETTLE_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_LAUNCH  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_SYNC    = 3'd4,
        ST_DECODE  = 3'd5,
        ST_HOLD    = 3'd6
    } tdc_state_e;

endpackage

// File: rtl/tdc_therm2bin.sv
// Combinational thermometer decoder: popcount of the captured taps plus
// bubble (non-thermometer) and overflow (all taps set) flags.
module tdc_therm2bin
    import tdc_pkg::*;
#(
    parameter int N  = TDC_N_DEF,
    parameter int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]  vec_i,
    output logic [CW-1:0] count_o,
    output logic          bubble_o,
    output logic          ovf_o
);

    logic [CW-1:0] count;
    logic          bubble;
    logic          seen_zero;

    // A bubble is any set tap sitting above a cleared tap nearer the launch point.
    always_comb begin
        count     = '0;
        bubble    = 1'b0;
        seen_zero = 1'b0;
        for (int i = 0; i < N; i++) begin
            count = count + CW'(vec_i[i]);
            if (vec_i[i] && seen_zero) begin
                bubble = 1'b1;
            end
            if (!vec_i[i]) begin
                seen_zero = 1'b1;
            end
        end
    end

    assign count_o  = count;
    assign bubble_o = bubble;
    assign ovf_o    = &vec_i;

endmodule

// File: rtl/tdc_ctrl.sv
// TDC measurement controller: settle, launch, capture, decode, hold-until-ready.
// Define TDC_CTRL_SYNC_EN to add a metastability flop stage (SYNC state) after capture.
module tdc_ctrl
    import tdc_pkg::*;
#(
    parameter int N      = TDC_N_DEF,
    parameter int SETTLE = TDC_SETTLE_DEF,
    parameter int CW     = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    output logic          launch_o,
    input  logic [N-1:0]  dl_in,
    output logic          busy_o,
    output logic          valid_o,
    input  logic          ready_i,
    output logic [CW-1:0] code_o,
    output logic          bubble_o,
    output logic          ovf_o
);

    localparam int SW = $clog2(SETTLE + 1);

    tdc_state_e    state_q, state_d;
    logic [SW-1:0] cnt_q, cnt_d;
    logic          launch_q, launch_d;
    logic          valid_q, valid_d;
    logic [N-1:0]  cap_q, cap_d;
    logic [CW-1:0] code_q, code_d;
    logic          bubble_q, bubble_d;
    logic          ovf_q, ovf_d;
    logic [N-1:0]  dec_src;
    logic [CW-1:0] dec_count;
    logic          dec_bubble;
    logic          dec_ovf;

`ifdef TDC_CTRL_SYNC_EN
    logic [N-1:0]  sync_q, sync_d;
    assign dec_src = sync_q;
`else
    assign dec_src = cap_q;
`endif

    tdc_therm2bin #(
        .N  (N),
        .CW (CW)
    ) u_therm2bin (
        .vec_i    (dec_src),
        .count_o  (dec_count),
        .bubble_o (dec_bubble),
        .ovf_o    (dec_ovf)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        launch_d = launch_q;
        valid_d  = valid_q;
        cap_d    = cap_q;
        code_d   = code_q;
        bubble_d = bubble_q;
        ovf_d    = ovf_q;
`ifdef TDC_CTRL_SYNC_EN
        sync_d   = sync_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SW'(SETTLE - 1);
                end
            end
            ST_SETTLE: begin
                launch_d = 1'b0;
                if (cnt_q == '0) begin
                    state_d  = ST_LAUNCH;
                    launch_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_LAUNCH: begin
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                cap_d = dl_in;
`ifdef TDC_CTRL_SYNC_EN
                state_d = ST_SYNC;
`else
                state_d = ST_DECODE;
`endif
            end
`ifdef TDC_CTRL_SYNC_EN
            ST_SYNC: begin
                sync_d  = cap_q;
                state_d = ST_DECODE;
            end
`endif
            ST_DECODE: begin
                code_d   = dec_count;
                bubble_d = dec_bubble;
                ovf_d    = dec_ovf;
                valid_d  = 1'b1;
                state_d  = ST_HOLD;
            end
            ST_HOLD: begin
                if (ready_i) begin
                    valid_d  = 1'b0;
                    launch_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                launch_d = 1'b0;
                valid_d  = 1'b0;
            end
        endcase
    end

    // Reset also clears the launch line asynchronously, aborting any measurement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            launch_q <= 1'b0;
            valid_q  <= 1'b0;
            cap_q    <= '0;
            code_q   <= '0;
            bubble_q <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef TDC_CTRL_SYNC_EN
            sync_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            launch_q <= launch_d;
            valid_q  <= valid_d;
            cap_q    <= cap_d;
            code_q   <= code_d;
            bubble_q <= bubble_d;
            ovf_q    <= ovf_d;
`ifdef TDC_CTRL_SYNC_EN
            sync_q   <= sync_d;
`endif
        end
    end

    assign launch_o = launch_q;
    assign busy_o   = (state_q != ST_IDLE);
    assign valid_o  = valid_q;
    assign code_o   = code_q;
    assign bubble_o = bubble_q;
    assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_tdc_ctrl.sv
// Self-checking bench for tdc_ctrl (N=32, SETTLE=4) against a popcount/thermometer reference model.
module tb_tdc_ctrl;

    localparam int N      = 32;
    localparam int SETTLE = 4;
    localparam int CW     = $clog2(N + 1);
`ifdef TDC_CTRL_SYNC_EN
    localparam int LAT    = SETTLE + 4;
`else
    localparam int LAT    = SETTLE + 3;
`endif
    localparam int CAP_EDGE = SETTLE + 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_i;
    logic          launch_o;
    logic [N-1:0]  dl_in;
    logic          busy_o;
    logic          valid_o;
    logic          ready_i;
    logic [CW-1:0] code_o;
    logic          bubble_o;
    logic          ovf_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tdc_ctrl #(
        .N      (N),
        .SETTLE (SETTLE)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .launch_o (launch_o),
        .dl_in    (dl_in),
        .busy_o   (busy_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .code_o   (code_o),
        .bubble_o (bubble_o),
        .ovf_o    (ovf_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: code is the number of set taps; a clean reading is exactly the
    // lowest `code` taps set; overflow means every tap set.
    task automatic model(input logic [N-1:0] vec, output int code, output bit bub, output bit ovf);
        logic [63:0] therm;
        code  = $countones(vec);
        therm = (64'd1 << code) - 64'd1;
        bub   = (vec != therm[N-1:0]);
        ovf   = (code == N);
    endtask

    // Caller positions time before a rising edge; that edge samples start_i.
    task automatic measure(input logic [N-1:0] vec, input int hold, input bit start_in_hold,
                           input bit idle_gap);
        int ecode;
        bit ebub;
        bit eovf;
        model(vec, ecode, ebub, eovf);
        start_i = 1'b1;
        dl_in   = $urandom;
        @(posedge clk);
        #1;
        check("busy_after_start", busy_o, 1'b1);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            start_i = 1'($urandom_range(0, 1));
            ready_i = (k < LAT) ? 1'($urandom_range(0, 1)) : 1'b0;
            dl_in   = (k == CAP_EDGE) ? vec : $urandom;
            @(posedge clk);
            #1;
            check($sformatf("valid_edge%0d", k), valid_o, (k >= LAT));
            check($sformatf("launch_edge%0d", k), launch_o, (k >= SETTLE));
            check($sformatf("busy_edge%0d", k), busy_o, 1'b1);
        end
        check("code", code_o, ecode);
        check("bubble", bubble_o, ebub);
        check("ovf", ovf_o, eovf);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            ready_i = 1'b0;
            start_i = start_in_hold;
            dl_in   = $urandom;
            @(posedge clk);
            #1;
            check("hold_valid", valid_o, 1'b1);
            check("hold_code", code_o, ecode);
            check("hold_bubble", bubble_o, ebub);
            check("hold_ovf", ovf_o, eovf);
            check("hold_launch", launch_o, 1'b1);
        end
        @(negedge clk);
        ready_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        ready_i = 1'b0;
        check("release_valid", valid_o, 1'b0);
        check("release_launch", launch_o, 1'b0);
        check("release_busy", busy_o, 1'b0);
        if (idle_gap) begin
            @(posedge clk);
            #1;
            check("no_queued_start", busy_o, 1'b0);
        end
    endtask

    initial begin
        logic [N-1:0] vec;
        logic [63:0]  t;
        int           sel;
        rst_n   = 1'b0;
        start_i = 1'b1;
        ready_i = 1'b0;
        dl_in   = '1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_launch", launch_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_valid", valid_o, 1'b0);
        check("rst_code", code_o, 0);
        check("rst_bubble", bubble_o, 1'b0);
        check("rst_ovf", ovf_o, 1'b0);
        start_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // First edge after reset release samples this start.
        measure(32'h0000_00FF, 0, 1'b0, 1'b0);
        measure(32'hFFFF_FFFF, 2, 1'b0, 1'b1);
        measure(32'h0000_0000, 1, 1'b0, 1'b0);
        measure(32'h0000_00F7, 3, 1'b1, 1'b0);
        measure(32'h0000_0FFF, 10, 1'b1, 1'b1);
        measure(32'h8000_0000, 0, 1'b0, 1'b0);

        // Reset in CAPTURE: launch and busy drop without a clock edge.
        start_i = 1'b1;
        dl_in   = '1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (SETTLE + 1) @(posedge clk);
        #2;
        check("pre_abort_launch", launch_o, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_launch", launch_o, 1'b0);
        check("abort_busy", busy_o, 1'b0);
        check("abort_valid", valid_o, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < LAT + 2; k++) begin
            @(posedge clk);
            #1;
            check("abort_no_valid", valid_o, 1'b0);
            check("abort_idle", busy_o, 1'b0);
        end

        for (int i = 0; i < 12; i++) begin
            sel = $urandom_range(0, 2);
            t   = (64'd1 << $urandom_range(0, N)) - 64'd1;
            if (sel == 0) begin
                vec = t[N-1:0];
            end else if (sel == 1) begin
                vec = $urandom;
            end else begin
                vec = t[N-1:0] ^ (32'd1 << $urandom_range(0, N - 1));
            end
            measure(vec, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'(i % 2));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
